// File: rtl/tilelink_ram_responder.sv
// rtl/tilelink_ram_responder.sv - TL-UL RAM responder, one outstanding request
// Optional macro TL_RESP_ALIGN_CHECK_EN adds address alignment and mask/lane consistency errors.
module tilelink_ram_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 2,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h4000_0000),
    parameter int                    MEM_WORDS    = 256,
    parameter int                    RESP_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_a_valid,
    output logic                    o_a_ready,
    input  logic [OPCODE_WIDTH-1:0] i_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  i_a_param,
    input  logic [SIZE_WIDTH-1:0]   i_a_size,
    input  logic [SRC_WIDTH-1:0]    i_a_source,
    input  logic [ADDR_WIDTH-1:0]   i_a_address,
    input  logic [MASK_WIDTH-1:0]   i_a_mask,
    input  logic [DATA_WIDTH-1:0]   i_a_data,
    output logic                    o_d_valid,
    input  logic                    i_d_ready,
    output logic [OPCODE_WIDTH-1:0] o_d_opcode,
    output logic [PARAM_WIDTH-1:0]  o_d_param,
    output logic [SIZE_WIDTH-1:0]   o_d_size,
    output logic [SRC_WIDTH-1:0]    o_d_source,
    output logic [SINK_WIDTH-1:0]   o_d_sink,
    output logic [DATA_WIDTH-1:0]   o_d_data,
    output logic                    o_d_error
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_BITS = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(MEM_WORDS * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state, w_next;
    logic                    r_a_ready;
    logic [3:0]              r_cnt;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [SIZE_WIDTH-1:0]   r_size;
    logic [SRC_WIDTH-1:0]    r_source;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [MASK_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_d_valid;
    logic [OPCODE_WIDTH-1:0] r_d_opcode;
    logic [SIZE_WIDTH-1:0]   r_d_size;
    logic [SRC_WIDTH-1:0]    r_d_source;
    logic [DATA_WIDTH-1:0]   r_d_data;
    logic                    r_d_error;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

    logic                    w_accept, w_handshake, w_enter_resp;
    logic [OPCODE_WIDTH-1:0] w_req_opcode;
    logic [SIZE_WIDTH-1:0]   w_req_size;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic [MASK_WIDTH-1:0]   w_req_mask;
    logic [DATA_WIDTH-1:0]   w_req_data;
    logic [ADDR_WIDTH-1:0]   w_off;
    logic [IDX_BITS-1:0]     w_idx;
    logic                    w_in_range, w_is_get, w_is_put, w_size_ok, w_align_err, w_err;
    logic                    w_unused;

    assign w_accept    = i_a_valid && r_a_ready;
    assign w_handshake = r_d_valid && i_d_ready;

    // With zero latency the decode happens on the accept edge, before the capture registers load.
    assign w_req_opcode = (r_state == S_IDLE) ? i_a_opcode  : r_opcode;
    assign w_req_size   = (r_state == S_IDLE) ? i_a_size    : r_size;
    assign w_req_addr   = (r_state == S_IDLE) ? i_a_address : r_addr;
    assign w_req_mask   = (r_state == S_IDLE) ? i_a_mask    : r_mask;
    assign w_req_data   = (r_state == S_IDLE) ? i_a_data    : r_data;

    assign w_off      = w_req_addr - BASE_ADDR;
    assign w_idx      = w_off[OFF_BITS +: IDX_BITS];
    assign w_in_range = (w_req_addr >= BASE_ADDR) && ({1'b0, w_req_addr} < LIMIT);
    assign w_is_get   = (w_req_opcode == OP_GET);
    assign w_is_put   = (w_req_opcode == OP_PUT_FULL) || (w_req_opcode == OP_PUT_PART);
    assign w_size_ok  = (w_req_size <= SIZE_WIDTH'(OFF_BITS));
    assign w_err      = !w_in_range || !(w_is_get || w_is_put) || !w_size_ok || w_align_err;
    assign w_unused   = ^{i_a_param, w_off};

`ifdef TL_RESP_ALIGN_CHECK_EN
    logic [OFF_BITS-1:0] w_low;
    assign w_low = w_req_addr[OFF_BITS-1:0];

    // Lane i belongs to the access when it falls in the same 2^size block as the address.
    always_comb begin
        w_align_err = 1'b0;
        if ((int'(w_low) & ((1 << w_req_size) - 1)) != 0) begin
            w_align_err = 1'b1;
        end
        for (int i = 0; i < BYTES; i++) begin
            if (w_is_put && w_req_mask[i] && ((i >> w_req_size) != (int'(w_low) >> w_req_size))) begin
                w_align_err = 1'b1;
            end
        end
    end
`else
    assign w_align_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)       w_next = (RESP_LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0)  w_next = S_RESP;
            S_RESP:  if (w_handshake)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a_ready  <= 1'b0;
            r_cnt      <= 4'd0;
            r_opcode   <= '0;
            r_size     <= '0;
            r_source   <= '0;
            r_addr     <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            r_a_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_opcode <= i_a_opcode;
                r_size   <= i_a_size;
                r_source <= i_a_source;
                r_addr   <= i_a_address;
                r_mask   <= i_a_mask;
                r_data   <= i_a_data;
                r_cnt    <= LAT_M1;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Payload is latched on RESP entry; d_valid follows one edge later.
            if (w_enter_resp) begin
                r_d_opcode <= w_is_get ? OP_ACK_DATA : OP_ACK;
                r_d_size   <= w_req_size;
                r_d_source <= (r_state == S_IDLE) ? i_a_source : r_source;
                r_d_error  <= w_err;
                r_d_data   <= (w_is_get && !w_err) ? r_mem[w_idx] : '0;
            end else if ((r_state == S_RESP) && !r_d_valid) begin
                r_d_valid <= 1'b1;
            end else if (w_handshake) begin
                r_d_valid  <= 1'b0;
                r_d_opcode <= '0;
                r_d_size   <= '0;
                r_d_source <= '0;
                r_d_data   <= '0;
                r_d_error  <= 1'b0;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && w_is_put && !w_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_req_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_req_data[8*b +: 8];
                end
            end
        end
    end

    assign o_a_ready  = r_a_ready;
    assign o_d_valid  = r_d_valid;
    assign o_d_opcode = r_d_opcode;
    assign o_d_param  = '0;
    assign o_d_size   = r_d_size;
    assign o_d_source = r_d_source;
    assign o_d_sink   = '0;
    assign o_d_data   = r_d_data;
    assign o_d_error  = r_d_error;
endmodule
